// File: rtl/param_shift_reg_if.sv
// Control, data and status bundle for param_shift_reg.
// The master modport drives the controls; the slave modport is the shift register.
interface param_shift_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned TAP_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             en_i;
    logic [1:0]       mode_i;
    logic [WIDTH-1:0] data_i;
    logic [TAP_W-1:0] tap_i;
    logic [WIDTH-1:0] data_o;
    logic [WIDTH-1:0] tap_o;
    logic             tap_valid_o;
    logic             full_o;
    logic [CNT_W-1:0] fill_o;

    modport master (
        output en_i, mode_i, data_i, tap_i,
        input  data_o, tap_o, tap_valid_o, full_o, fill_o
    );

    modport slave (
        input  en_i, mode_i, data_i, tap_i,
        output data_o, tap_o, tap_valid_o, full_o, fill_o
    );
endinterface

// File: rtl/param_shift_reg.sv
// WIDTH x DEPTH delay line with shift/rotate/hold/clear modes, a run-time
// selectable tap and a saturating fill count that qualifies the tap.
module param_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    param_shift_reg_if.slave   bus
);
    localparam int unsigned TAP_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;
    logic             fill_full;
    logic             tap_in_range;
    logic [WIDTH-1:0] tap_sel;

    assign fill_full = (fill_q == CNT_W'(DEPTH));

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        fill_d = fill_q;
        if (bus.en_i) begin
            case (mode_e'(bus.mode_i))
                MODE_SHIFT: begin
                    stage_d[0] = bus.data_i;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        stage_d[k] = stage_q[k-1];
                    end
                    fill_d = fill_full ? fill_q : fill_q + CNT_W'(1);
                end
                MODE_ROTATE: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        stage_d[k] = stage_q[k-1];
                    end
                end
                MODE_CLEAR: begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        stage_d[k] = '0;
                    end
                    fill_d = '0;
                end
                default: begin
                    // MODE_HOLD keeps the defaults
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            fill_q <= fill_d;
        end
    end

    // Tap mux built as a compare chain so out-of-range indices never touch the array.
    always_comb begin
        tap_sel = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (bus.tap_i == TAP_W'(k)) begin
                tap_sel = stage_q[k];
            end
        end
    end

    assign tap_in_range    = ({1'b0, bus.tap_i} < (TAP_W + 1)'(DEPTH));
    assign bus.tap_o       = tap_sel;
    assign bus.tap_valid_o = tap_in_range && (fill_q > CNT_W'(bus.tap_i));
    assign bus.data_o      = stage_q[DEPTH-1];
    assign bus.full_o      = fill_full;
    assign bus.fill_o      = fill_q;
endmodule
